// File: rtl/seq_pkg.sv
// Shared opcodes, FSM state encoding and dispatch-unit selector for the
// instruction issue sequencer.
package seq_pkg;

    localparam int unsigned INST_WIDTH = 16;
    localparam int unsigned ADDR_WIDTH = 5;
    localparam int unsigned OP_WIDTH   = 4;

    localparam logic [OP_WIDTH-1:0] OP_HALT = 4'b0000;
    localparam logic [OP_WIDTH-1:0] OP_LD   = 4'b0001;
    localparam logic [OP_WIDTH-1:0] OP_ST   = 4'b0010;
    localparam logic [OP_WIDTH-1:0] OP_PUSH = 4'b0100;
    localparam logic [OP_WIDTH-1:0] OP_PULL = 4'b0101;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_ISSUE,
        ST_WAIT,
        ST_END
    } state_e;

    typedef enum logic {
        UNIT_LS,
        UNIT_SA
    } unit_e;

    typedef struct packed {
        logic  legal;
        logic  halt;
        unit_e unit;
    } dec_t;

endpackage

// File: rtl/seq_decode.sv
// Combinational opcode classifier: dispatchable, halt, and target unit.
module seq_decode
    import seq_pkg::*;
(
    input  logic [OP_WIDTH-1:0] opcode_i,
    output dec_t                dec_o
);

    always_comb begin
        dec_o      = '0;
        dec_o.unit = UNIT_LS;
        case (opcode_i)
            OP_LD, OP_ST: begin
                dec_o.legal = 1'b1;
                dec_o.unit  = UNIT_LS;
            end
            OP_PUSH, OP_PULL: begin
                dec_o.legal = 1'b1;
                dec_o.unit  = UNIT_SA;
            end
            OP_HALT: dec_o.halt = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/instr_issue_sequencer.sv
// In-order fetch/issue controller: one instruction in flight to LD/ST or PUSH/PULL.
// Optional SEQ_PERF_CNT_EN adds a saturating retired-instruction counter.
module instr_issue_sequencer
    import seq_pkg::*;
#(
    parameter logic [ADDR_WIDTH-1:0] LAST_PC = 5'd30
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_pc,
    input  logic                  abort,
    output logic [ADDR_WIDTH-1:0] imem_addr,
    input  logic [INST_WIDTH-1:0] imem_data,
    output logic                  ls_valid,
    input  logic                  ls_ready,
    output logic                  sa_valid,
    input  logic                  sa_ready,
    output logic [INST_WIDTH-1:0] issue_instr,
    input  logic                  ls_done,
    input  logic                  sa_done,
    output logic                  busy,
    output logic                  done,
`ifdef SEQ_PERF_CNT_EN
    output logic [15:0]           retired_cnt,
`endif
    output logic                  err_illegal
);

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
    logic [INST_WIDTH-1:0]   ir_q, ir_d;
    unit_e                   unit_q, unit_d;
    logic                    err_q, err_d;
    dec_t                    dec;
    logic                    unit_done;
    logic                    accept;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0]             cnt_q, cnt_d;
`endif

    seq_decode u_decode (
        .opcode_i (imem_data[INST_WIDTH-1 -: OP_WIDTH]),
        .dec_o    (dec)
    );

    always_comb begin
        ls_valid  = 1'b0;
        sa_valid  = 1'b0;
        if (state_q == ST_ISSUE) begin
            ls_valid = (unit_q == UNIT_LS);
            sa_valid = (unit_q == UNIT_SA);
        end
    end

    assign accept      = (ls_valid & ls_ready) | (sa_valid & sa_ready);
    // The other unit's completion pulse must not advance the program.
    assign unit_done   = (unit_q == UNIT_LS) ? ls_done : sa_done;
    assign imem_addr   = pc_q;
    assign issue_instr = ir_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_END);
    assign err_illegal = err_q;
`ifdef SEQ_PERF_CNT_EN
    assign retired_cnt = cnt_q;
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        unit_d  = unit_q;
        err_d   = err_q;
`ifdef SEQ_PERF_CNT_EN
        cnt_d   = cnt_q;
`endif
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        pc_d    = start_pc & ~ADDR_WIDTH'(1);
                        err_d   = 1'b0;
`ifdef SEQ_PERF_CNT_EN
                        cnt_d   = '0;
`endif
                        state_d = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    ir_d   = imem_data;
                    unit_d = dec.unit;
                    if (dec.legal) begin
                        state_d = ST_ISSUE;
                    end else if (dec.halt) begin
                        state_d = ST_END;
                    end else begin
                        err_d   = 1'b1;
                        state_d = ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    if (accept) state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (unit_done) begin
`ifdef SEQ_PERF_CNT_EN
                        if (cnt_q != 16'hFFFF) cnt_d = cnt_q + 16'd1;
`endif
                        if (pc_q == LAST_PC) begin
                            state_d = ST_END;
                        end else begin
                            pc_d    = pc_q + ADDR_WIDTH'(2);
                            state_d = ST_FETCH;
                        end
                    end
                end
                ST_END:  state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            ir_q    <= '0;
            unit_q  <= UNIT_LS;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
            unit_q  <= unit_d;
            err_q   <= err_d;
        end
    end

`ifdef SEQ_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`endif

endmodule

// File: tb/tb_instr_issue_sequencer.sv
// Randomized and directed checks of instr_issue_sequencer against a
// program-level reference model of fetch/dispatch order.
module tb_instr_issue_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [4:0]  start_pc;
    logic        abort;
    logic [4:0]  imem_addr;
    logic [15:0] imem_data;
    logic        ls_valid, ls_ready;
    logic        sa_valid, sa_ready;
    logic [15:0] issue_instr;
    logic        ls_done, sa_done;
    logic        busy, done, err_illegal;
`ifdef SEQ_PERF_CNT_EN
    logic [15:0] retired_cnt;
`endif

    logic [15:0] rom [16];
    logic [15:0] exp_q [$];
    bit          exp_done, exp_err;
    int          exp_pc;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr[4:1]];

    instr_issue_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .start_pc    (start_pc),
        .abort       (abort),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .ls_valid    (ls_valid),
        .ls_ready    (ls_ready),
        .sa_valid    (sa_valid),
        .sa_ready    (sa_ready),
        .issue_instr (issue_instr),
        .ls_done     (ls_done),
        .sa_done     (sa_done),
        .busy        (busy),
        .done        (done),
`ifdef SEQ_PERF_CNT_EN
        .retired_cnt (retired_cnt),
`endif
        .err_illegal (err_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit is_ls_op(input logic [3:0] op);
        return (op == 4'd1) || (op == 4'd2);
    endfunction

    function automatic bit is_sa_op(input logic [3:0] op);
        return (op == 4'd4) || (op == 4'd5);
    endfunction

    // Walk the program the way the specification describes it.
    task automatic model(input logic [4:0] spc);
        int p;
        logic [3:0] op;
        p = int'(spc) & 30;
        exp_q.delete();
        exp_done = 0;
        exp_err  = 0;
        while (1) begin
            op = rom[p / 2][15:12];
            if (is_ls_op(op) || is_sa_op(op)) begin
                exp_q.push_back(rom[p / 2]);
                if (p == 30) begin
                    exp_done = 1;
                    break;
                end
                p += 2;
            end else if (op == 4'd0) begin
                exp_done = 1;
                break;
            end else begin
                exp_err = 1;
                break;
            end
        end
        exp_pc = p;
    endtask

    task automatic fill_rand(input bit legal_only);
        logic [3:0] ops [10];
        ops = '{4'd1, 4'd2, 4'd4, 4'd5, 4'd1, 4'd4, 4'd2, 4'd5, 4'd0, 4'd15};
        for (int i = 0; i < 16; i++) begin
            rom[i] = 16'($urandom);
            if (legal_only)
                rom[i][15:12] = ops[$urandom_range(0, 7)];
            else if ($urandom_range(0, 9) == 0)
                rom[i][15:12] = (i % 2 == 0) ? 4'd0 : 4'd15;
            else
                rom[i][15:12] = ops[$urandom_range(0, 7)];
        end
    endtask

    task automatic run(input logic [4:0] spc, input int rmin, input int rmax,
                       input int dmin, input int dmax, input bit noise);
        logic [15:0] held, ew;
        int  phase, hold, dcnt, nva, idx;
        bit  fin, sel_ls;
        model(spc);
        @(negedge clk);
        start    = 1;
        start_pc = spc;
        @(negedge clk);
        start = 0;
        check("busy_after_start", busy, 1);
        check("err_clear_on_start", err_illegal, 0);
        check("first_fetch_addr", imem_addr, 32'(spc & 5'h1e));
        phase  = 0;
        nva    = 2;
        idx    = 0;
        fin    = 0;
        sel_ls = 0;
        hold   = 0;
        dcnt   = 0;
        held   = '0;
        for (int c = 1; c < 2000 && !fin; c++) begin
            if (c > 1) @(negedge clk);
            ls_done = 0;
            sa_done = 0;
            check("one_valid_max", 32'(ls_valid & sa_valid), 0);
            if (done || !busy) begin
                check("end_done", done, exp_done);
                check("end_err", err_illegal, exp_err);
                check("dispatch_count", idx, exp_q.size());
                fin = 1;
            end else if (phase == 2) begin
                ls_ready = 0;
                sa_ready = 0;
                check("wait_no_valid", 32'(ls_valid | sa_valid), 0);
                dcnt--;
                if (dcnt == 0) begin
                    if (sel_ls) ls_done = 1;
                    else        sa_done = 1;
                    nva   = c + 2;
                    idx++;
                    phase = 0;
                end else if (noise && $urandom_range(0, 1) == 1) begin
                    if (sel_ls) sa_done = 1;
                    else        ls_done = 1;
                end
            end else begin
                if (phase == 0 && (ls_valid || sa_valid)) begin
                    ew     = (idx < exp_q.size()) ? exp_q[idx] : 16'hDEAD;
                    sel_ls = is_ls_op(ew[15:12]);
                    check("issue_latency", c, nva);
                    check("issue_instr", issue_instr, ew);
                    check("ls_select", ls_valid, sel_ls);
                    check("sa_select", sa_valid, !sel_ls);
                    held  = issue_instr;
                    hold  = $urandom_range(rmin, rmax);
                    phase = 1;
                end
                if (phase == 1) begin
                    check("valid_held", 32'(ls_valid | sa_valid), 1);
                    check("instr_stable", issue_instr, held);
                    if (hold == 0) begin
                        if (sel_ls) ls_ready = 1;
                        else        sa_ready = 1;
                        dcnt  = $urandom_range(dmin, dmax);
                        phase = 2;
                    end else begin
                        ls_ready = 0;
                        sa_ready = 0;
                        hold--;
                    end
                end
            end
        end
        check("run_finished", fin, 1);
        ls_ready = 0;
        sa_ready = 0;
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_end", busy, 0);
        check("final_pc", imem_addr, exp_pc);
        check("final_err", err_illegal, exp_err);
    endtask

    initial begin
        rst_n    = 0;
        start    = 0;
        start_pc = '0;
        abort    = 0;
        ls_ready = 0;
        sa_ready = 0;
        ls_done  = 0;
        sa_done  = 0;
        for (int i = 0; i < 16; i++) rom[i] = 16'h1000;
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ls_valid", ls_valid, 0);
        check("rst_sa_valid", sa_valid, 0);
        check("rst_issue_instr", issue_instr, 0);
        check("rst_imem_addr", imem_addr, 0);
        check("rst_err", err_illegal, 0);
        repeat (2) @(negedge clk);
        rst_n = 1;

        // LD, ST, HALT with immediate ready and done three cycles later
        fill_rand(0);
        rom[0] = 16'h1ABC;
        rom[1] = 16'h2DEF;
        rom[2] = 16'h0000;
        run(5'd0, 0, 0, 3, 3, 0);

        // PUSH stalled four cycles by sa_ready
        rom[0] = 16'h4321;
        rom[1] = 16'h0000;
        run(5'd0, 4, 4, 2, 2, 0);

        // illegal opcode at pc=4, then a clean run clears the error
        rom[0] = 16'h1111;
        rom[1] = 16'h5555;
        rom[2] = 16'hF00D;
        run(5'd0, 0, 1, 1, 2, 0);
        rom[2] = 16'h0000;
        run(5'd0, 0, 1, 1, 2, 0);

        // full ROM of dispatchable words ends at the last address
        fill_rand(1);
        run(5'd0, 0, 2, 1, 4, 1);

        // odd start_pc, LD waiting while sa_done pulses
        fill_rand(1);
        rom[2] = 16'h1357;
        rom[3] = 16'h0000;
        run(5'd5, 0, 1, 3, 5, 1);

        for (int t = 0; t < 20; t++) begin
            fill_rand($urandom_range(0, 3) == 0);
            run(5'($urandom_range(0, 31)), 0, 3, 1, 4, 1'($urandom_range(0, 1)));
        end

        // abort while ISSUE stalled
        for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
        @(negedge clk);
        start = 1;
        start_pc = 5'd0;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        check("pre_abort_issue", ls_valid, 1);
        start    = 1;
        start_pc = 5'd10;
        @(negedge clk);
        start = 0;
        check("start_ignored_busy", imem_addr, 0);
        check("still_issuing", ls_valid, 1);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_issue_idle", busy, 0);
        check("abort_issue_valid", ls_valid, 0);
        check("abort_issue_done", done, 0);

        // abort while WAIT, later ls_done is ignored
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        ls_ready = 1;
        @(negedge clk);
        ls_ready = 0;
        check("in_wait_busy", busy, 1);
        check("in_wait_valid", ls_valid, 0);
        abort = 1;
        @(negedge clk);
        abort = 0;
        check("abort_wait_idle", busy, 0);
        ls_done = 1;
        @(negedge clk);
        ls_done = 0;
        check("late_done_ignored", busy, 0);
        check("abort_no_done", done, 0);

        // start and abort together
        start = 1;
        abort = 1;
        @(negedge clk);
        start = 0;
        abort = 0;
        check("start_abort_idle", busy, 0);

        // asynchronous reset mid-ISSUE
        start = 1;
        @(negedge clk);
        start = 0;
        @(negedge clk);
        check("pre_reset_valid", ls_valid, 1);
        #2 rst_n = 0;
        #1;
        check("async_rst_valid", ls_valid, 0);
        check("async_rst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1;

        fill_rand(0);
        run(5'd2, 0, 2, 1, 3, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
